// File: rtl/rv3n_func_lsu_ot_pkg.sv
// -----------------------------------------------------------------------------
// rv3n_lsu_pkg
// Shared definitions for the rv3n outstanding-transaction load/store unit:
// operation-field positions, access-size codes, the in-flight tag record and
// the load-data extension helper.
// -----------------------------------------------------------------------------
package rv3n_lsu_pkg;

  // Bit positions inside func_lsu_req_para
  localparam int unsigned PARA_SZ_LSB  = 0;
  localparam int unsigned PARA_UNS     = 2;
  localparam int unsigned PARA_ST      = 3;
  localparam int unsigned PARA_GRP_LSB = 4;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  // Byte offset is at most 3 bits wide (XLEN=64); narrower configs zero-pad.
  localparam int unsigned TAG_OFF_W = 3;

  typedef struct packed {
    logic [3:0]           para;
    logic [TAG_OFF_W-1:0] off;
  } lsu_tag_t;

  // Extract the low 8<<sz bits of an already lane-shifted word and widen it.
  // Doubleword (and anything at full width) passes through unchanged.
  function automatic logic [63:0] lsu_extend(input logic [63:0] r,
                                             input lsu_size_e   sz,
                                             input logic        uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic [63:0]        res;
    b = r[7:0];
    h = r[15:0];
    w = r[31:0];
    case (sz)
      SZ_B:    res = uns ? {56'd0, r[7:0]}  : 64'(b);
      SZ_H:    res = uns ? {48'd0, r[15:0]} : 64'(h);
      SZ_W:    res = uns ? {32'd0, r[31:0]} : 64'(w);
      default: res = r;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rv3n_func_lsu_ot_if.sv
// -----------------------------------------------------------------------------
// rv3n_func_lsu_ot_if
// Bundles the issue-side request/ack signals and the data-memory port of the
// load/store unit.
//   slave  : the LSU view (consumes requests and dmem responses).
//   master : the issue logic / memory model view.
// Signals:
//   func_lsu_req_*   request valid, para, imm, pc (reserved), operand0/1
//   func_lsu_ack_*   completion valid, data, err, busy
//   func_lsu_shortcut_data  early-forward data of the head entry
//   dmem_*           req/gnt handshake, cmd, width, addr, wdata, rdata/resp/err
// -----------------------------------------------------------------------------
interface rv3n_func_lsu_ot_if #(
  parameter int XLEN  = 32,
  parameter int IMM_W = 13
);
  logic             func_lsu_req_valid;
  logic [7:0]       func_lsu_req_para;
  logic [IMM_W-1:0] func_lsu_req_imm;
  logic [XLEN-1:0]  func_lsu_req_pc;
  logic [XLEN-1:0]  func_lsu_req_operand0;
  logic [XLEN-1:0]  func_lsu_req_operand1;
  logic             func_lsu_ack_valid;
  logic [XLEN-1:0]  func_lsu_ack_data;
  logic             func_lsu_ack_err;
  logic             func_lsu_ack_busy;
  logic [XLEN-1:0]  func_lsu_shortcut_data;
  logic             dmem_req;
  logic             dmem_gnt;
  logic             dmem_cmd;
  logic [1:0]       dmem_width;
  logic [XLEN-1:0]  dmem_addr;
  logic [XLEN-1:0]  dmem_wdata;
  logic [XLEN-1:0]  dmem_rdata;
  logic             dmem_resp;
  logic             dmem_err;

  modport slave (
    input  func_lsu_req_valid, func_lsu_req_para, func_lsu_req_imm,
           func_lsu_req_pc, func_lsu_req_operand0, func_lsu_req_operand1,
           dmem_gnt, dmem_rdata, dmem_resp, dmem_err,
    output func_lsu_ack_valid, func_lsu_ack_data, func_lsu_ack_err,
           func_lsu_ack_busy, func_lsu_shortcut_data,
           dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata
  );

  modport master (
    output func_lsu_req_valid, func_lsu_req_para, func_lsu_req_imm,
           func_lsu_req_pc, func_lsu_req_operand0, func_lsu_req_operand1,
           dmem_gnt, dmem_rdata, dmem_resp, dmem_err,
    input  func_lsu_ack_valid, func_lsu_ack_data, func_lsu_ack_err,
           func_lsu_ack_busy, func_lsu_shortcut_data,
           dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata
  );
endinterface

// File: rtl/rv3n_func_lsu_ot_tagq.sv
// -----------------------------------------------------------------------------
// rv3n_lsu_tagq
// In-order tag FIFO for outstanding dmem requests. Circular buffer whose
// pointers wrap modulo DEPTH; push and pop may happen in the same cycle even
// when full (the caller only pushes into a full queue while popping).
// Ports:
//   clk, rst     clock, synchronous active-high reset (clears pointers/count)
//   push_i       write push_data_i at the tail
//   push_data_i  tag to store
//   pop_i        retire the head entry
//   cnt_o        number of valid entries
//   head_o       oldest entry
// -----------------------------------------------------------------------------
module rv3n_lsu_tagq
  import rv3n_lsu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  lsu_tag_t      push_data_i,
  input  logic          pop_i,
  output logic [CW-1:0] cnt_o,
  output lsu_tag_t      head_o
);

  lsu_tag_t      mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) wptr_d = wrap_inc(wptr_q);
    if (pop_i)  rptr_d = wrap_inc(rptr_q);
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Tag storage carries no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= push_data_i;
  end

  assign cnt_o  = cnt_q;
  assign head_o = mem_q[rptr_q];

endmodule

// File: rtl/rv3n_func_lsu_ot.sv
// -----------------------------------------------------------------------------
// rv3n_func_lsu_ot
// Load/store unit with up to OT_DEPTH dmem requests in flight. Requests issue
// combinationally, completions are acked in the dmem_resp cycle in issue order.
// Store data is lane-replicated; load data is shifted by the byte offset
// recorded at issue and then sign/zero-extended.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   rv3n_func_lsu_ot_if.slave (request/ack and dmem port)
// Build option:
//   LSU_MISALIGN_EXC_EN  when defined, misaligned accesses are never issued;
//                        once the unit drains they complete as an error ack
//                        carrying the effective address.
// -----------------------------------------------------------------------------
module rv3n_func_lsu_ot
  import rv3n_lsu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int OT_DEPTH = 2,
  parameter int IMM_W    = 13
) (
  input  logic              clk,
  input  logic              rst,
  rv3n_func_lsu_ot_if.slave bus
);

  localparam int OFFW = $clog2(XLEN / 8);
  localparam int CW   = $clog2(OT_DEPTH + 1);

  logic            active;
  lsu_size_e       sz;
  logic [XLEN-1:0] ea;
  logic [XLEN-1:0] sz_mask;
  logic [OFFW-1:0] off;
  logic            slot_free;
  logic            blocked;
  logic            issue;
  logic            pop;
  logic [CW-1:0]   cnt;
  lsu_tag_t        push_tag;
  lsu_tag_t        head;
  lsu_size_e       head_sz;
  logic [XLEN-1:0] r;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wdata;
  logic            trap_ack;
  logic [XLEN-1:0] trap_addr;
  logic            unused_ok;

  // Requests with para[5:4] != 0 belong to another functional unit.
  assign active  = bus.func_lsu_req_valid &
                   (bus.func_lsu_req_para[PARA_GRP_LSB +: 2] == 2'b00);
  assign sz      = lsu_size_e'(bus.func_lsu_req_para[PARA_SZ_LSB +: 2]);
  assign ea      = bus.func_lsu_req_operand0 + XLEN'($signed(bus.func_lsu_req_imm));
  assign sz_mask = (XLEN'(1) << sz) - XLEN'(1);
  assign off     = ea[OFFW-1:0];

  always_comb begin
    case (sz)
      SZ_B:    wdata = {(XLEN/8){bus.func_lsu_req_operand1[7:0]}};
      SZ_H:    wdata = {(XLEN/16){bus.func_lsu_req_operand1[15:0]}};
      SZ_W:    wdata = {(XLEN/32){bus.func_lsu_req_operand1[31:0]}};
      default: wdata = bus.func_lsu_req_operand1;
    endcase
  end

`ifdef LSU_MISALIGN_EXC_EN
  logic            misalign;
  logic            err_pend_q, err_pend_d;
  logic [XLEN-1:0] ea_q;

  assign misalign = (off & sz_mask[OFFW-1:0]) != '0;
  // The trap ack cycle consumes the held request, so nothing issues then.
  assign blocked  = misalign | err_pend_q;

  // Trap only once every older access has completed, keeping acks in order.
  always_comb begin
    err_pend_d = 1'b0;
    if (!err_pend_q)
      err_pend_d = active & misalign & (cnt == '0) & ~bus.dmem_resp;
  end

  always_ff @(posedge clk) begin
    if (rst) err_pend_q <= 1'b0;
    else     err_pend_q <= err_pend_d;
  end

  always_ff @(posedge clk) begin
    if (err_pend_d) ea_q <= ea;
  end

  assign trap_ack  = err_pend_q;
  assign trap_addr = ea_q;
`else
  assign blocked   = 1'b0;
  assign trap_ack  = 1'b0;
  assign trap_addr = '0;
`endif

  // A response retiring in this cycle frees a slot for a same-cycle issue.
  assign slot_free = (cnt < CW'(OT_DEPTH)) | bus.dmem_resp;

  assign bus.dmem_req   = active & ~rst & ~blocked & slot_free;
  assign bus.dmem_cmd   = bus.func_lsu_req_para[PARA_ST];
  assign bus.dmem_width = bus.func_lsu_req_para[PARA_SZ_LSB +: 2];
  assign bus.dmem_addr  = ea & ~sz_mask;
  assign bus.dmem_wdata = wdata;

  assign issue    = bus.dmem_req & bus.dmem_gnt;
  // Responses with nothing outstanding (e.g. after a reset) are dropped.
  assign pop      = ~rst & bus.dmem_resp & (cnt != '0);
  assign push_tag = '{para: bus.func_lsu_req_para[3:0], off: TAG_OFF_W'(off)};

  rv3n_lsu_tagq #(
    .DEPTH (OT_DEPTH)
  ) u_tagq (
    .clk         (clk),
    .rst         (rst),
    .push_i      (issue),
    .push_data_i (push_tag),
    .pop_i       (pop),
    .cnt_o       (cnt),
    .head_o      (head)
  );

  assign head_sz   = lsu_size_e'(head.para[PARA_SZ_LSB +: 2]);
  assign r         = bus.dmem_rdata >> {head.off, 3'b000};
  assign load_ext  = XLEN'(lsu_extend(64'(r), head_sz, head.para[PARA_UNS]));
  assign load_data = head.para[PARA_ST] ? '0 : load_ext;

  assign bus.func_lsu_shortcut_data = (head_sz >= SZ_W) ? r : XLEN'($signed(r[15:0]));

  assign bus.func_lsu_ack_valid = ~rst & (pop | trap_ack);
  assign bus.func_lsu_ack_err   = ~rst & (trap_ack | (pop & bus.dmem_err));
  assign bus.func_lsu_ack_busy  = ~rst & active & ~trap_ack & ~issue;

  always_comb begin
    bus.func_lsu_ack_data = '0;
    if (!rst) begin
      if (trap_ack)  bus.func_lsu_ack_data = trap_addr;
      else if (pop)  bus.func_lsu_ack_data = load_data;
    end
  end

  // pc and the upper para bits are reserved and intentionally not consumed.
  assign unused_ok = ^{bus.func_lsu_req_pc, bus.func_lsu_req_para[7:6]};

endmodule
